fetch_stage: RTL and testbench

Instruction fetch stage of the 5-stage RV32I pipeline. Holds the program counter, fetches from instruction memory over a single-outstanding request/response handshake, and presents `InstrF`, `PCF`, `PCPlus4F` plus a valid flag to the IF/ID pipeline register. It absorbs variable memory latency and stalls with a one-entry holding buffer, and kills wrong-path fetches on an execute-stage redirect.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// Single-outstanding request/response handshake:
//   req    fetch -> mem   request valid
//   addr   fetch -> mem   word-aligned byte address
//   ready  mem -> fetch   request accepted when req && ready
//   rvalid mem -> fetch   response valid, in order
//   rdata  mem -> fetch   response instruction
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Holds the program counter, fetches over a single-outstanding imem handshake,
// buffers one returned instruction so memory latency and hazard stalls are
// absorbed, and kills wrong-path fetches when execute redirects.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   StallF              hold the IF/ID-facing output registers
//   PCSrcE, PCTargetE   execute-stage redirect and target (bits [1:0] ignored)
//   imem                instruction-memory bus (fetch_stage_if.master)
//   InstrF, PCF,        registered instruction, its address, address + 4
//   PCPlus4F
//   FetchValidF         InstrF is real; otherwise InstrF is the NOP bubble
//
// Optional feature macro FETCH_PERF_CNT_EN adds FetchBubbleCnt and
// RedirectCnt (32-bit wrapping counters). Without it they are absent.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          StallF,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrF,
  output logic [31:0]   PCF,
  output logic [31:0]   PCPlus4F,
  output logic          FetchValidF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   FetchBubbleCnt,
  output logic [31:0]   RedirectCnt
`endif
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_req_pc;
  logic [31:0] w_req_pc_nxt;
  logic        w_req;
  logic        w_buf_wr;
  logic [31:0] w_target;

  logic        r_buf_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;

  logic [31:0] r_instr;
  logic [31:0] r_pcf;
  logic [31:0] r_pcp4;
  logic        r_valid;

  // Redirect target forced to a word boundary.
  assign w_target = PCTargetE & 32'hFFFF_FFFC;

  assign imem.req    = w_req;
  assign imem.addr   = r_pc;
  assign InstrF      = r_instr;
  assign PCF         = r_pcf;
  assign PCPlus4F    = r_pcp4;
  assign FetchValidF = r_valid;

  // Next-state logic for the request FSM, fetch PC and kill flag.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_kill_nxt   = r_kill;
    w_req_pc_nxt = r_req_pc;
    w_req        = 1'b0;
    w_buf_wr     = 1'b0;
    case (r_state)
      S_REQ: begin
        // Do not request while a buffered instruction is stuck behind a
        // stall; gating with reset_n keeps req low during reset.
        w_req = reset_n && !PCSrcE && (!r_buf_valid || !StallF);
        if (w_req && imem.ready) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + 32'd4;
          w_state_nxt  = S_WAIT;
        end else begin
          w_state_nxt  = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          // A response belonging to a killed path is dropped here.
          w_buf_wr    = !r_kill && !PCSrcE;
          w_kill_nxt  = 1'b0;
          w_state_nxt = S_REQ;
        end else if (PCSrcE) begin
          // Response still in flight: remember to discard it on arrival.
          w_kill_nxt  = 1'b1;
        end else begin
          w_kill_nxt  = r_kill;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
        w_kill_nxt  = 1'b0;
      end
    endcase
    if (PCSrcE) begin
      w_pc_nxt = w_target;
    end else begin
      w_pc_nxt = w_pc_nxt;
    end
  end

  // FSM state, fetch PC, kill flag and in-flight request address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_kill   <= 1'b0;
      r_req_pc <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_kill   <= w_kill_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  // Holding buffer and IF/ID-facing output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_valid <= 1'b0;
      r_buf_instr <= NOP_INSTR;
      r_buf_pc    <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pcf       <= RESET_PC;
      r_pcp4      <= RESET_PC + 32'd4;
      r_valid     <= 1'b0;
    end else if (PCSrcE) begin
      // Redirect overrides the stall: flush buffer and outputs, PCF held.
      r_buf_valid <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
    end else begin
      if (!StallF) begin
        if (r_buf_valid) begin
          r_instr <= r_buf_instr;
          r_pcf   <= r_buf_pc;
          r_pcp4  <= r_buf_pc + 32'd4;
          r_valid <= 1'b1;
        end else begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      end else begin
        r_instr <= r_instr;
        r_valid <= r_valid;
      end
      // A write in the same cycle as a drain leaves the new entry valid.
      if (w_buf_wr) begin
        r_buf_valid <= 1'b1;
        r_buf_instr <= imem.rdata;
        r_buf_pc    <= r_req_pc;
      end else if (!StallF) begin
        r_buf_valid <= 1'b0;
      end else begin
        r_buf_valid <= r_buf_valid;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_redirect_cnt;

  assign FetchBubbleCnt = r_bubble_cnt;
  assign RedirectCnt    = r_redirect_cnt;

  // Bubble and redirect event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_cnt   <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      // An unstalled edge loads a bubble on redirect or with an empty buffer.
      if (!StallF && (PCSrcE || !r_buf_valid)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
      if (PCSrcE) begin
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end else begin
        r_redirect_cnt <= r_redirect_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table, hand-written
// reset-in-flight sequence, and randomized runs against a queue-based model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        pcsrc;
  logic [31:0] target;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pcp4_f;
  logic        valid_f;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bub_cnt;
  logic [31:0] redir_cnt;
`endif

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .StallF     (stall),
    .PCSrcE     (pcsrc),
    .PCTargetE  (target),
    .imem       (imem_bus),
    .InstrF     (instr_f),
    .PCF        (pc_f),
    .PCPlus4F   (pcp4_f),
    .FetchValidF(valid_f)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchBubbleCnt(bub_cnt),
    .RedirectCnt   (redir_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    logic        ready;
    logic        rvalid;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcf;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                              input logic rd, input logic rv, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.pcsrc = p; v.target = t; v.ready = rd; v.rvalid = rv;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pcf = ep;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model state: transaction view of the fetch stage.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_out;
  logic [31:0] m_out_addr;
  int          m_cd;
  logic        m_killed;
  logic        e_valid;
  logic [31:0] e_pcf;
  logic [31:0] e_instr;
  int          m_bubbles;
  int          m_redirs;

  task automatic apply_reset();
    reset_n = 1'b0;
    stall = 1'b0; pcsrc = 1'b0; target = 32'd0;
    imem_bus.ready = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_q.delete();
    m_pc = 32'd0; m_out = 1'b0; m_out_addr = 32'd0; m_cd = 0; m_killed = 1'b0;
    e_valid = 1'b0; e_pcf = 32'd0; e_instr = NOP;
    m_bubbles = 0; m_redirs = 0;
  endtask

  // Runs n cycles of random stimulus from a negedge and checks every cycle.
  task automatic run_model(input int n, input int stall_pct, input int redir_pct,
                           input int ready_pct, input int lat_min, input int lat_max);
    logic exp_req;
    logic acc;
    logic resp;
    ent_t e;
    for (int c = 0; c < n; c++) begin
      stall  = ($urandom_range(99) < stall_pct);
      pcsrc  = ($urandom_range(99) < redir_pct);
      target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF4 | $urandom_range(3)) : $urandom;
      imem_bus.ready = ($urandom_range(99) < ready_pct);
      if (m_out && m_cd == 0) begin
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = m_out_addr ^ PAT;
      end else begin
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = $urandom;
      end
      #1;
      exp_req = !m_out && !pcsrc && !(m_q.size() != 0 && stall);
      chk("rnd_req", imem_bus.req, exp_req);
      if (exp_req) chk("rnd_addr", imem_bus.addr, m_pc);
      acc  = exp_req && imem_bus.ready;
      resp = m_out && imem_bus.rvalid;
      @(posedge clk);
      if (pcsrc) begin
        m_redirs++;
        if (!stall) m_bubbles++;
        e_valid = 1'b0;
        e_instr = NOP;
        m_q.delete();
        if (resp) begin
          m_out = 1'b0; m_killed = 1'b0;
        end else if (m_out) begin
          m_killed = 1'b1;
        end
        m_pc = target & 32'hFFFF_FFFC;
      end else begin
        if (!stall) begin
          if (m_q.size() > 0) begin
            e = m_q.pop_front();
            e_valid = 1'b1; e_pcf = e.pc; e_instr = e.data;
          end else begin
            e_valid = 1'b0; e_instr = NOP; m_bubbles++;
          end
        end
        if (resp) begin
          if (!m_killed) begin
            e.pc = m_out_addr; e.data = m_out_addr ^ PAT;
            m_q.push_back(e);
          end
          m_out = 1'b0; m_killed = 1'b0;
        end
      end
      if (acc) begin
        m_out = 1'b1; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
        m_cd = $urandom_range(lat_max, lat_min);
      end else if (m_out) begin
        m_cd--;
      end
      #1;
      chk("rnd_valid", valid_f, e_valid);
      chk("rnd_instr", instr_f, e_instr);
      chk("rnd_pcf", pc_f, e_pcf);
      chk("rnd_pcp4", pcp4_f, e_pcf + 32'd4);
      @(negedge clk);
    end
  endtask

  vec_t tbl[27];

  initial begin
    logic [31:0] last_acc;
    // Directed zero-wait table, including stall, redirect-in-wait and
    // redirect-with-response corner cases.
    tbl[0]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h000, 1'b0,32'h000);
    tbl[1]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h004, 1'b0,32'h000);
    tbl[2]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h004, 1'b1,32'h000);
    tbl[3]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h008, 1'b0,32'h000);
    tbl[4]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h008, 1'b1,32'h004);
    tbl[5]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h00C, 1'b0,32'h004);
    tbl[6]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h00C, 1'b1,32'h008);
    tbl[7]  = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h010, 1'b0,32'h008);
    tbl[8]  = mk(1'b1,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h010, 1'b0,32'h008);
    tbl[9]  = mk(1'b1,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h010, 1'b0,32'h008);
    tbl[10] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h010, 1'b1,32'h00C);
    tbl[11] = mk(1'b1,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h014, 1'b1,32'h00C);
    tbl[12] = mk(1'b1,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h014, 1'b1,32'h00C);
    tbl[13] = mk(1'b1,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h014, 1'b1,32'h00C);
    tbl[14] = mk(1'b1,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h014, 1'b1,32'h00C);
    tbl[15] = mk(1'b1,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h014, 1'b1,32'h00C);
    tbl[16] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h014, 1'b1,32'h010);
    tbl[17] = mk(1'b1,1'b1,32'h102,1'b1,1'b0, 1'b0,32'h018, 1'b0,32'h010);
    tbl[18] = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h100, 1'b0,32'h010);
    tbl[19] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h100, 1'b0,32'h010);
    tbl[20] = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h104, 1'b0,32'h010);
    tbl[21] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h104, 1'b1,32'h100);
    tbl[22] = mk(1'b0,1'b1,32'h200,1'b1,1'b1, 1'b0,32'h108, 1'b0,32'h100);
    tbl[23] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h200, 1'b0,32'h100);
    tbl[24] = mk(1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h204, 1'b0,32'h100);
    tbl[25] = mk(1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h204, 1'b1,32'h200);
    tbl[26] = mk(1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h204, 1'b0,32'h200);

    // Reset values while reset is held.
    reset_n = 1'b1;
    stall = 1'b0; pcsrc = 1'b0; target = 32'd0;
    imem_bus.ready = 1'b1; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'd0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", valid_f, 32'd0);
    chk("rst_instr", instr_f, NOP);
    chk("rst_pcf", pc_f, 32'd0);
    chk("rst_pcp4", pcp4_f, 32'd4);
    chk("rst_req", imem_bus.req, 32'd0);
    chk("rst_addr", imem_bus.addr, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    last_acc = 32'd0;
    for (int i = 0; i < 27; i++) begin
      stall = tbl[i].stall; pcsrc = tbl[i].pcsrc; target = tbl[i].target;
      imem_bus.ready  = tbl[i].ready;
      imem_bus.rvalid = tbl[i].rvalid;
      imem_bus.rdata  = last_acc ^ PAT;
      #1;
      chk($sformatf("tbl%0d_req", i), imem_bus.req, tbl[i].exp_req);
      chk($sformatf("tbl%0d_addr", i), imem_bus.addr, tbl[i].exp_addr);
      @(posedge clk);
      if (tbl[i].ready && tbl[i].exp_req) last_acc = tbl[i].exp_addr;
      #1;
      chk($sformatf("tbl%0d_valid", i), valid_f, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_pcf", i), pc_f, tbl[i].exp_pcf);
      chk($sformatf("tbl%0d_pcp4", i), pcp4_f, tbl[i].exp_pcf + 32'd4);
      chk($sformatf("tbl%0d_instr", i), instr_f,
          tbl[i].exp_valid ? (tbl[i].exp_pcf ^ PAT) : NOP);
      @(negedge clk);
    end

    // Reset pulsed while a request for 0x204 is outstanding.
    stall = 1'b0; pcsrc = 1'b0;
    imem_bus.ready = 1'b0; imem_bus.rvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", valid_f, 32'd0);
    chk("midrst_instr", instr_f, NOP);
    chk("midrst_pcf", pc_f, 32'd0);
    chk("midrst_pcp4", pcp4_f, 32'd4);
    chk("midrst_req", imem_bus.req, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    imem_bus.ready = 1'b1; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h204 ^ PAT;
    #1;
    chk("post_rst_req", imem_bus.req, 32'd1);
    chk("post_rst_addr", imem_bus.addr, 32'd0);
    @(negedge clk);
    imem_bus.rvalid = 1'b0;
    #1;
    chk("post_rst_wait", imem_bus.req, 32'd0);
    @(negedge clk);
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h0 ^ PAT;
    @(negedge clk);
    imem_bus.rvalid = 1'b0;
    #1;
    chk("post_rst_req2", imem_bus.req, 32'd1);
    chk("post_rst_addr2", imem_bus.addr, 32'd4);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", valid_f, 32'd1);
    chk("post_rst_out_pcf", pc_f, 32'd0);
    chk("post_rst_out_instr", instr_f, PAT);
    @(negedge clk);

    // Fixed 3-cycle memory latency, no stalls or redirects.
    apply_reset();
    run_model(40, 0, 0, 100, 2, 2);
    // Randomized stalls, redirects, backpressure and latency.
    run_model(3000, 25, 6, 75, 0, 3);
    // Drain with long stall bursts and rare redirects.
    run_model(500, 60, 2, 100, 0, 1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_bubbles", bub_cnt, m_bubbles);
    chk("perf_redirects", redir_cnt, m_redirs);
    // Two redirects followed by four bubble edges.
    apply_reset();
    imem_bus.ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pcsrc = (k < 2);
      target = 32'h40;
      @(negedge clk);
    end
    pcsrc = 1'b0;
    #1;
    chk("perf_redir2", redir_cnt, 32'd2);
    chk("perf_bubble6", bub_cnt, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
